// File: rtl/mux_pipe_pkg.sv
// mux_pipe_pkg: constants and handshake helpers shared by the mux_pipe slice.
//   MIN_NUM_IN / MAX_NUM_IN : legal range for the mux_pipe NUM_IN parameter.
//   hs_fire()               : a beat moves when valid and ready are both high
//                             in the same cycle.
package mux_pipe_pkg;

  localparam int MIN_NUM_IN = 2;
  localparam int MAX_NUM_IN = 16;

  // Handshake rule used by every port of this slice: the producer holds
  // valid (and its data) until it sees ready; a beat transfers on the rising
  // edge at the end of any cycle where both are high.
  function automatic logic hs_fire(input logic valid, input logic ready);
    return valid && ready;
  endfunction

endpackage

// File: rtl/mux_pipe_skid_reg.sv
// mux_pipe_skid_reg: WIDTH-generic 2-entry valid/ready skid buffer.
//   clk, rst        : rising-edge clock, synchronous active-high reset
//   flush           : drop both buffered beats (wins over any load)
//   in_data/in_valid/in_ready : upstream side; in_ready depends only on
//                               the skid flop and rst
//   in_accept       : in_valid && in_ready, exported so the parent can act
//                     on exactly the beats this buffer takes
//   out_data/out_valid/out_ready : downstream side, driven from the main flop
module mux_pipe_skid_reg
  import mux_pipe_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             in_accept,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  logic             main_valid_q, main_valid_d;
  logic [WIDTH-1:0] main_data_q,  main_data_d;
  logic             skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0] skid_data_q,  skid_data_d;
  logic             load_en;

  // No combinational path from out_ready: a stall is absorbed by the skid
  // entry, and in_ready only drops once that entry is actually occupied.
  assign in_ready  = !skid_valid_q && !rst;
  assign in_accept = hs_fire(in_valid, in_ready);

  // The main register may take a new value when it is empty or its current
  // beat is leaving this cycle.
  assign load_en = !main_valid_q || out_ready;

  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;

    if (load_en) begin
      if (skid_valid_q) begin
        // Older skid beat goes first; in_ready is low so nothing new arrives.
        main_valid_d = 1'b1;
        main_data_d  = skid_data_q;
        skid_valid_d = 1'b0;
      end else if (in_accept) begin
        main_valid_d = 1'b1;
        main_data_d  = in_data;
      end else begin
        // Data is kept so out_data does not toggle on an empty output.
        main_valid_d = 1'b0;
      end
    end else if (in_accept) begin
      skid_valid_d = 1'b1;
      skid_data_d  = in_data;
    end

    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      main_data_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
    end
  end

  assign out_valid = main_valid_q;
  assign out_data  = main_data_q;

endmodule

// File: rtl/mux_pipe.sv
// mux_pipe: NUM_IN:1 selector of WIDTH-bit inputs feeding a registered,
// back-pressured output stage with flush.
//   clk, rst   : rising-edge clock, synchronous active-high reset
//   in_data    : NUM_IN*WIDTH flattened inputs, input k at [k*WIDTH +: WIDTH]
//   sel        : binary select, only looked at on an accepted beat
//   in_valid / in_ready   : upstream handshake
//   flush      : discard every buffered beat (and any beat accepted now)
//   out_data / out_valid / out_ready : downstream handshake, registered
//   sel_err    : sticky, set when an accepted beat had sel >= NUM_IN;
//                cleared only by rst
module mux_pipe
  import mux_pipe_pkg::*;
#(
  parameter  int WIDTH  = 32,
  parameter  int NUM_IN = 4,
  localparam int SEL_W  = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    flush,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sel_err
);

  if (NUM_IN < MIN_NUM_IN || NUM_IN > MAX_NUM_IN) begin : g_bad_num_in
    $error("mux_pipe: NUM_IN out of supported range");
  end

  logic [WIDTH-1:0] sel_data;
  logic             sel_in_range;
  logic             accept;
  logic             sel_err_q, sel_err_d;

  // Input 0 is the fallback for an out-of-range select, so the loop starts
  // at 1 and an unmatched sel leaves the default in place.
  always_comb begin
    sel_data = in_data[WIDTH-1:0];
    for (int k = 1; k < NUM_IN; k++) begin
      if (sel == SEL_W'(k)) begin
        sel_data = in_data[k*WIDTH +: WIDTH];
      end
    end
  end

  assign sel_in_range = (int'(sel) < NUM_IN);

  mux_pipe_skid_reg #(
    .WIDTH (WIDTH)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_data   (sel_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_accept (accept),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  // A bad select on an accepted beat is recorded even if flush discards the
  // beat; sel only matters when a beat is accepted.
  always_comb begin
    sel_err_d = sel_err_q | (accept & ~sel_in_range);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_err_q <= 1'b0;
    end else begin
      sel_err_q <= sel_err_d;
    end
  end

  assign sel_err = sel_err_q;

endmodule

// File: tb/tb_mux_pipe.sv
module tb_mux_pipe;
  localparam int W = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT a: NUM_IN = 4 ----------------
  logic [4*W-1:0] a_in_data;
  logic [1:0]     a_sel;
  logic           a_in_valid, a_in_ready, a_flush;
  logic [W-1:0]   a_out_data;
  logic           a_out_valid, a_out_ready, a_sel_err;

  mux_pipe #(.WIDTH(W), .NUM_IN(4)) u_dut_a (
    .clk       (clk),
    .rst       (rst),
    .in_data   (a_in_data),
    .sel       (a_sel),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .flush     (a_flush),
    .out_data  (a_out_data),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready),
    .sel_err   (a_sel_err)
  );

  // ---------------- DUT b: NUM_IN = 3 ----------------
  logic [3*W-1:0] b_in_data;
  logic [1:0]     b_sel;
  logic           b_in_valid, b_in_ready, b_flush;
  logic [W-1:0]   b_out_data;
  logic           b_out_valid, b_out_ready, b_sel_err;

  mux_pipe #(.WIDTH(W), .NUM_IN(3)) u_dut_b (
    .clk       (clk),
    .rst       (rst),
    .in_data   (b_in_data),
    .sel       (b_sel),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .flush     (b_flush),
    .out_data  (b_out_data),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .sel_err   (b_sel_err)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] pat[4];

  task automatic check_eq(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic valid, input int s, input logic ordy);
    a_in_valid  = valid;
    a_sel       = 2'(s);
    a_out_ready = ordy;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int beats;
    int cycles;
    int idx;
    logic stall;
    logic [W-1:0] held;

    pat[0] = 32'hAAAA0000;
    pat[1] = 32'hBBBB0001;
    pat[2] = 32'hCCCC0002;
    pat[3] = 32'hDDDD0003;
    a_in_data = {pat[3], pat[2], pat[1], pat[0]};
    b_in_data = {pat[2], pat[1], pat[0]};
    drive_a(1'b0, 0, 1'b0);
    a_flush = 1'b0;
    b_sel = 2'd0; b_in_valid = 1'b0; b_flush = 1'b0; b_out_ready = 1'b1;

    // Reset state
    rst = 1'b1;
    step();
    step();
    check_eq("rst_out_valid", W'(a_out_valid), 0);
    check_eq("rst_out_data", a_out_data, 0);
    check_eq("rst_in_ready", W'(a_in_ready), 0);
    check_eq("rst_sel_err", W'(a_sel_err), 0);
    check_eq("rst_b_out_valid", W'(b_out_valid), 0);
    rst = 1'b0;
    #1;
    check_eq("rel_in_ready", W'(a_in_ready), 1);

    // Pass-through: sel=2 then sweep 0..3 back to back
    drive_a(1'b1, 2, 1'b1);
    step();
    check_eq("pt_valid", W'(a_out_valid), 1);
    check_eq("pt_data_sel2", a_out_data, 32'hCCCC0002);
    for (int s = 0; s < 4; s++) begin
      a_sel = 2'(s);
      step();
      check_eq("sweep_valid", W'(a_out_valid), 1);
      check_eq("sweep_data", a_out_data, pat[s]);
    end
    a_in_valid = 1'b0;
    step();
    check_eq("pt_empty", W'(a_out_valid), 0);

    // Stall and skid
    drive_a(1'b1, 0, 1'b1);
    step();
    check_eq("stall_first", a_out_data, pat[0]);
    drive_a(1'b1, 1, 1'b0);
    step();
    check_eq("stall_hold0", a_out_data, pat[0]);
    check_eq("stall_valid", W'(a_out_valid), 1);
    check_eq("stall_in_ready", W'(a_in_ready), 0);
    a_sel = 2'd2;
    step();
    check_eq("stall_hold1", a_out_data, pat[0]);
    check_eq("stall_in_ready2", W'(a_in_ready), 0);
    a_out_ready = 1'b1;
    step();
    check_eq("drain_skid", a_out_data, pat[1]);
    check_eq("drain_in_ready", W'(a_in_ready), 1);
    step();
    check_eq("drain_c", a_out_data, pat[2]);
    a_sel = 2'd3;
    step();
    check_eq("drain_d", a_out_data, pat[3]);
    a_in_valid = 1'b0;
    step();
    check_eq("drain_empty", W'(a_out_valid), 0);

    // Flush with main and skid both full
    drive_a(1'b1, 0, 1'b1);
    step();
    drive_a(1'b1, 1, 1'b0);
    step();
    check_eq("fl_full_in_ready", W'(a_in_ready), 0);
    a_flush = 1'b1;
    a_sel = 2'd2;
    step();
    check_eq("fl_out_valid", W'(a_out_valid), 0);
    check_eq("fl_in_ready", W'(a_in_ready), 1);
    a_flush = 1'b0;
    drive_a(1'b0, 0, 1'b1);
    step();
    check_eq("fl_after", W'(a_out_valid), 0);
    // Flush while accepting into an empty stage
    a_flush = 1'b1;
    drive_a(1'b1, 3, 1'b1);
    step();
    check_eq("fl_acc_valid", W'(a_out_valid), 0);
    a_flush = 1'b0;
    a_in_valid = 1'b0;
    step();
    check_eq("fl_acc_gone", W'(a_out_valid), 0);
    check_eq("a_no_sel_err", W'(a_sel_err), 0);

    // Out-of-range select on DUT b (NUM_IN = 3)
    b_sel = 2'd3;
    step();
    check_eq("oor_idle_no_err", W'(b_sel_err), 0);
    b_in_valid = 1'b1;
    step();
    check_eq("oor_data_in0", b_out_data, pat[0]);
    check_eq("oor_valid", W'(b_out_valid), 1);
    check_eq("oor_err_set", W'(b_sel_err), 1);
    b_sel = 2'd1;
    step();
    check_eq("oor_legal_data", b_out_data, pat[1]);
    check_eq("oor_err_sticky", W'(b_sel_err), 1);
    b_in_valid = 1'b0;
    b_flush = 1'b1;
    step();
    check_eq("oor_flush_valid", W'(b_out_valid), 0);
    check_eq("oor_flush_err", W'(b_sel_err), 1);
    b_flush = 1'b0;
    step();
    check_eq("oor_err_kept", W'(b_sel_err), 1);

    // Reset mid-stall with two beats buffered
    drive_a(1'b1, 1, 1'b1);
    step();
    drive_a(1'b1, 2, 1'b0);
    step();
    check_eq("rm_full", W'(a_in_ready), 0);
    rst = 1'b1;
    #1;
    check_eq("rm_in_ready_rst", W'(a_in_ready), 0);
    step();
    check_eq("rm_out_valid", W'(a_out_valid), 0);
    check_eq("rm_out_data", a_out_data, 0);
    check_eq("rm_in_ready", W'(a_in_ready), 0);
    check_eq("rm_b_err_clr", W'(b_sel_err), 0);
    rst = 1'b0;
    drive_a(1'b1, 3, 1'b1);
    #1;
    check_eq("rm_rel_ready", W'(a_in_ready), 1);
    step();
    check_eq("rm_new_valid", W'(a_out_valid), 1);
    check_eq("rm_new_data", a_out_data, pat[3]);
    a_in_valid = 1'b0;
    step();
    check_eq("rm_idle", W'(a_out_valid), 0);

    // Random valid/ready toggling against the expected queue
    beats = 0;
    cycles = 0;
    while (beats < 10000 && cycles < 60000) begin
      a_in_valid  = ($urandom_range(0, 9) < 7);
      a_out_ready = ($urandom_range(0, 9) < 6);
      a_sel       = 2'($urandom_range(0, 3));
      a_in_data   = {$urandom, $urandom, $urandom, $urandom};
      #1;
      if (a_out_valid && a_out_ready) begin
        check_eq("rnd_beat_expected", W'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) check_eq("rnd_data", a_out_data, exp_q.pop_front());
      end
      if (a_in_valid && a_in_ready) begin
        idx = int'(a_sel);
        exp_q.push_back(a_in_data[idx*W +: W]);
        beats++;
      end
      stall = a_out_valid && !a_out_ready;
      held  = a_out_data;
      step();
      cycles++;
      if (stall) begin
        check_eq("rnd_stall_valid", W'(a_out_valid), 1);
        check_eq("rnd_stall_data", a_out_data, held);
      end
      check_eq("rnd_out_valid", W'(a_out_valid), W'(exp_q.size() != 0));
      check_eq("rnd_in_ready", W'(a_in_ready), W'(exp_q.size() < 2));
    end
    if (beats < 10000) check_eq("rnd_cycle_budget", W'(beats), 10000);

    // Drain whatever remains
    a_in_valid  = 1'b0;
    a_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (a_out_valid) begin
        check_eq("end_beat_expected", W'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) check_eq("end_data", a_out_data, exp_q.pop_front());
      end
      step();
    end
    check_eq("end_q_empty", W'(exp_q.size()), 0);
    check_eq("end_out_valid", W'(a_out_valid), 0);

    // Final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mux_pipe.md
Name: mux_pipe

Overview:
- Parametrised N:1 datapath selector with a registered, back-pressured output stage.
- Generalises the 2:1 operand mux to NUM_IN inputs of WIDTH bits.
- Adds a valid/ready handshake with a 2-entry skid buffer, so a pipeline stage can stall without losing data.
- Sits between the forwarding sources and a downstream stage (e.g. ALU operand or writeback select) and supports pipeline flush.

Parameters:
- WIDTH, 32, data width of each input and of the output.
- NUM_IN, 4, number of selectable inputs; legal range 2..16.
- SEL_W, $clog2(NUM_IN), width of the select field; derived localparam, not overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_data  input  NUM_IN*WIDTH  flattened inputs; input k occupies bits [k*WIDTH +: WIDTH].
- sel  input  SEL_W  binary select; sampled only on an accepted beat.
- in_valid  input  1  upstream beat present.
- in_ready  output  1  block can accept; equals !skid_valid && !rst.
- flush  input  1  discard all buffered beats.
- out_data  output  WIDTH  registered selected data.
- out_valid  output  1  out_data holds a beat.
- out_ready  input  1  downstream takes the beat this cycle.
- sel_err  output  1  sticky flag: an accepted beat had sel >= NUM_IN.

Behaviour:
- Accept condition: in_valid && in_ready. Transfer condition: out_valid && out_ready.
- Selection on accept: d = in_data[sel*WIDTH +: WIDTH] when sel < NUM_IN. Otherwise d = input 0 and sel_err is set on the next edge.
- State: main register {main_valid, main_data} drives out_valid/out_data. Skid register is {skid_valid, skid_data}.
- Main load enable: !main_valid || out_ready.
  - If enabled and skid_valid: main <= skid, skid_valid <= 0. An accept is impossible that cycle because in_ready = 0.
  - Else if enabled and accept: main <= d, main_valid <= 1.
  - Else if enabled and no source: main_valid <= 0.
  - If not enabled and accept: skid <= d, skid_valid <= 1.
- Latency: accept at edge N makes the beat visible on out_* after edge N; one cycle when the output is empty.
- Throughput: one beat per cycle while out_ready stays high.
- Ordering: strict FIFO; the skid beat always precedes any new beat.
- in_ready is registered-only (no combinational path from out_ready). It drops the cycle after a beat enters skid and rises the cycle after skid drains.
- out_data holds its value while out_valid && !out_ready; it must not change under a stall.
- Flush (priority over all loads):
  - main_valid and skid_valid go to 0 on the edge.
  - A beat accepted in the flush cycle is discarded.
  - sel_err is unaffected.
  - in_ready is 1 in the following cycle.
- Reset: out_valid = 0, out_data = 0, skid_valid = 0, skid_data = 0, sel_err = 0. in_ready = 0 while rst is high and 1 on the first cycle after release.
- Reset mid-stall drops both buffered beats; no partial state survives.
- Flush and rst together behave as rst.
- Out-of-range sel on a non-accepted cycle has no effect.

Decomposition:
- No shared package needed.
- SEL_W is a local derived parameter. Handshake-transfer and flush-priority conventions go in the shared pipeline defines header alongside existing stage-control constants.
- Natural sub-module: skid_reg (WIDTH-generic 2-entry valid/ready skid buffer). mux_pipe = combinational index select + skid_reg + sel_err flop.
- skid_reg is reusable by later pipeline stages.

Test Plan:
- Pass-through, NUM_IN=4, WIDTH=32: in_data = {0xDDDD0003, 0xCCCC0002, 0xBBBB0001, 0xAAAA0000}, sel = 2, in_valid = 1, out_ready = 1 → out_data = 0xCCCC0002 with out_valid = 1 one cycle later. Sweeping sel 0..3 on consecutive cycles → 4 beats in order, no bubbles.
- Stall and skid: stream sel = 0,1,2,3 with out_ready = 0 from cycle 2 → out_data holds 0xAAAA0000, the beat with sel = 1 sits in skid, in_ready = 0. Raising out_ready → 0xAAAA0000, 0xBBBB0001, then the remaining beats, none lost or duplicated.
- Out-of-range select, NUM_IN=3: sel = 3 accepted → out_data = input 0, sel_err = 1 and stays 1 through later legal beats and through flush; cleared only by rst.
- Flush with full buffer: main and skid both valid, flush = 1 with in_valid = 1 → next cycle out_valid = 0, in_ready = 1. The flush-cycle beat never appears at the output.
- Reset mid-operation: rst asserted while stalled with 2 beats buffered → out_valid = 0, out_data = 0, in_ready = 0 during rst. After release, a new beat emerges after one cycle.
- Randomised valid/ready toggling (10k beats) against a scoreboard queue → output sequence matches accepted sequence exactly, and out_data is stable whenever out_valid && !out_ready.
